alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between two requesters, req0 and req1. In the SISD core these are the execute stage and the address/branch-compare path. Each requester issues an op/operand pair with a valid/ready handshake. The arbiter grants round-robin, drives the ALU from registered operands, and captures result and zero_flag into a per-requester response held until acknowledged. Only one operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One operation in flight: accept in IDLE, execute in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_operand1,
    output logic [WIDTH-1:0] alu_operand2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero_flag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   owner;
    logic   grant_any;
    logic   grant_sel;
    logic   rsp_ack;

    // Arbitration: a tie goes to the requester that did not win last time
    always_comb begin
        grant_any = (state == IDLE) && !rst && (req0_valid || req1_valid);
        grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        rsp_ack   = owner ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b0;
        req0_ready = grant_any && !grant_sel;
        req1_ready = grant_any && grant_sel;
        busy       = (state != IDLE);
    end

    // Operand issue and per-requester response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            alu_op       <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            rsp0_valid   <= 1'b0;
            rsp0_result  <= '0;
            rsp0_zero    <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_result  <= '0;
            rsp1_zero    <= 1'b0;
        end else begin
            if (grant_any) begin
                last_grant   <= grant_sel;
                owner        <= grant_sel;
                alu_op       <= grant_sel ? req1_op : req0_op;
                alu_operand1 <= grant_sel ? req1_a : req0_a;
                alu_operand2 <= grant_sel ? req1_b : req0_b;
            end
            if (state == EXEC) begin
                if (owner) begin
                    rsp1_valid  <= 1'b1;
                    rsp1_result <= alu_result;
                    rsp1_zero   <= alu_zero_flag;
                end else begin
                    rsp0_valid  <= 1'b1;
                    rsp0_result <= alu_result;
                    rsp0_zero   <= alu_zero_flag;
                end
            end
            if (state == RESP && rsp_ack) begin
                if (owner) begin
                    rsp1_valid <= 1'b0;
                end else begin
                    rsp0_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic             req0_valid = 0, req0_ready, rsp0_valid, rsp0_ready = 1, rsp0_zero;
    logic [OPW-1:0]   req0_op = '0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, rsp0_result;
    logic             req1_valid = 0, req1_ready, rsp1_valid, rsp1_ready = 1, rsp1_zero;
    logic [OPW-1:0]   req1_op = '0;
    logic [WIDTH-1:0] req1_a = '0, req1_b = '0, rsp1_result;
    logic [WIDTH-1:0] alu_operand1, alu_operand2, alu_result;
    logic [OPW-1:0]   alu_op;
    logic             alu_zero_flag, busy;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero_flag(alu_zero_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [OPW-1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return b;
        endcase
    endfunction

    assign alu_result    = alu_fn(alu_op, alu_operand1, alu_operand2);
    assign alu_zero_flag = (alu_result == '0);

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: phase 0 waiting, 1 executing, 2 response outstanding
    int               m_phase = 0;
    bit               m_last  = 1;
    bit               m_owner = 0;
    bit               m_rv[2];
    logic [WIDTH-1:0] m_rr[2];
    bit               m_rz[2];
    logic [OPW-1:0]   m_op = '0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_pend = '0;

    function automatic bit pick();
        if (req0_valid && req1_valid) return !m_last;
        return req1_valid;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            chk_en  = 1;
            m_phase = 0; m_last = 1; m_owner = 0;
            m_rv[0] = 0; m_rv[1] = 0; m_rr[0] = '0; m_rr[1] = '0; m_rz[0] = 0; m_rz[1] = 0;
            m_op = '0; m_a = '0; m_b = '0;
        end else if (m_phase == 0) begin
            if (req0_valid || req1_valid) begin
                m_owner = pick();
                m_last  = m_owner;
                m_op    = m_owner ? req1_op : req0_op;
                m_a     = m_owner ? req1_a : req0_a;
                m_b     = m_owner ? req1_b : req0_b;
                m_pend  = alu_fn(m_op, m_a, m_b);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_rv[m_owner] = 1;
            m_rr[m_owner] = m_pend;
            m_rz[m_owner] = (m_pend == '0);
            m_phase = 2;
        end else if ((m_owner ? rsp1_ready : rsp0_ready)) begin
            m_rv[m_owner] = 0;
            m_phase = 0;
        end
    end

    int          grant_q[$];
    int          acc_cyc_q[$];
    logic [32:0] rsp0_q[$];
    logic [32:0] rsp1_q[$];
    bit          acc0 = 0, acc1 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit any;
            any = !rst && m_phase == 0 && (req0_valid || req1_valid);
            check("req0_ready", req0_ready, any && !pick());
            check("req1_ready", req1_ready, any && pick());
            check("busy", busy, m_phase != 0);
            check("rsp0_valid", rsp0_valid, m_rv[0]);
            check("rsp0_result", rsp0_result, m_rr[0]);
            check("rsp0_zero", rsp0_zero, m_rz[0]);
            check("rsp1_valid", rsp1_valid, m_rv[1]);
            check("rsp1_result", rsp1_result, m_rr[1]);
            check("rsp1_zero", rsp1_zero, m_rz[1]);
            check("alu_op", alu_op, m_op);
            check("alu_operand1", alu_operand1, m_a);
            check("alu_operand2", alu_operand2, m_b);
        end
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0) begin grant_q.push_back(0); acc_cyc_q.push_back(cyc); end
        if (acc1) begin grant_q.push_back(1); acc_cyc_q.push_back(cyc); end
        if (rsp0_valid && rsp0_ready) rsp0_q.push_back({rsp0_zero, rsp0_result});
        if (rsp1_valid && rsp1_ready) rsp1_q.push_back({rsp1_zero, rsp1_result});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit n, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (n ? req1_ready : req0_ready) begin
                ok = 1;
                return;
            end
            @(posedge clk);
        end
    endtask

    logic [OPW-1:0]   t_op[4] = '{4'd0, 4'd1, 4'd2, 4'd4};
    logic [WIDTH-1:0] t_a[4]  = '{32'd10, 32'd50, 32'hF0, 32'hFF};
    logic [WIDTH-1:0] t_b[4]  = '{32'd20, 32'd8, 32'h3C, 32'hFF};
    logic [32:0]      t_r[4]  = '{33'd30, 33'd42, 33'h30, 33'h1_0000_0000};

    initial begin
        bit ok;
        tick(); tick();
        rst = 0;
        check("rst_busy", busy, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_alu_operand1", alu_operand1, 0);

        // Single add from requester 0
        req0_valid = 1; req0_op = 4'd0; req0_a = 8; req0_b = 8;
        #1 check("t1_ready_T", req0_ready, 1);
        tick(); req0_valid = 0;
        check("t1_busy_T1", busy, 1);
        check("t1_rsp_T1", rsp0_valid, 0);
        tick();
        check("t1_rsp_valid_T2", rsp0_valid, 1);
        check("t1_rsp_result", rsp0_result, 16);
        check("t1_rsp_zero", rsp0_zero, 0);
        check("t1_rsp1_idle", rsp1_valid, 0);
        tick();
        check("t1_idle_busy", busy, 0);

        // Zero result from requester 1
        req1_valid = 1; req1_op = 4'd0; req1_a = 0; req1_b = 0;
        #1 check("t2_ready", req1_ready, 1);
        tick(); req1_valid = 0;
        check("t2_busy_T1", busy, 1);
        check("t2_operand1", alu_operand1, 0);
        check("t2_operand2", alu_operand2, 0);
        tick();
        check("t2_busy_T2", busy, 1);
        check("t2_rsp_valid", rsp1_valid, 1);
        check("t2_rsp_result", rsp1_result, 0);
        check("t2_rsp_zero", rsp1_zero, 1);
        tick();

        // Tie from reset, round-robin
        rst = 1; tick(); rst = 0;
        grant_q.delete(); rsp0_q.delete(); rsp1_q.delete();
        req0_valid = 1; req0_op = 4'd0; req0_a = 1; req0_b = 2;
        req1_valid = 1; req1_op = 4'd0; req1_a = 5; req1_b = 5;
        repeat (9) tick();
        req0_valid = 0; req1_valid = 0;
        repeat (3) tick();
        check("t3_grants", grant_q.size(), 3);
        check("t3_grant0", grant_q[0], 0);
        check("t3_grant1", grant_q[1], 1);
        check("t3_grant2", grant_q[2], 0);
        check("t3_rsp0_count", rsp0_q.size(), 2);
        check("t3_rsp0_result", rsp0_q[0], 3);
        check("t3_rsp1_result", rsp1_q[0], 10);

        // Back-pressure on requester 0 with requester 1 pending
        rsp0_ready = 0;
        req0_valid = 1; req0_op = 4'd0; req0_a = 100; req0_b = 23;
        #1 check("t4_ready", req0_ready, 1);
        tick(); req0_valid = 0;
        req1_valid = 1; req1_op = 4'd2; req1_a = 32'hFF; req1_b = 32'h0F;
        tick();
        check("t4_rsp_valid", rsp0_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_result", rsp0_result, 123);
            check("t4_hold_zero", rsp0_zero, 0);
            check("t4_hold_busy", busy, 1);
            check("t4_hold_req1", req1_ready, 0);
            tick();
        end
        rsp0_ready = 1;
        #1 check("t4_ack_req1", req1_ready, 0);
        tick();
        check("t4_done_valid", rsp0_valid, 0);
        check("t4_req1_accept", req1_ready, 1);
        tick(); req1_valid = 0;
        tick();
        check("t4_rsp1_result", rsp1_result, 32'h0F);
        tick();

        // Reset during EXEC
        req0_valid = 1; req0_op = 4'd4; req0_a = 3; req0_b = 4;
        #1 check("t5_ready", req0_ready, 1);
        tick(); req0_valid = 0;
        check("t5_exec_busy", busy, 1);
        rst = 1;
        tick();
        check("t5_rsp0_valid", rsp0_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_alu_op", alu_op, 0);
        check("t5_operand1", alu_operand1, 0);
        check("t5_operand2", alu_operand2, 0);
        check("t5_rsp1_result", rsp1_result, 0);
        rst = 0;
        req0_valid = 1; req1_valid = 1;
        #1 check("t5_tie_req0", req0_ready, 1);
        check("t5_tie_req1", req1_ready, 0);
        tick(); req0_valid = 0; req1_valid = 0;
        repeat (3) tick();

        // Back-to-back throughput from requester 0
        acc_cyc_q.delete(); rsp0_q.delete();
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req0_op = t_op[i]; req0_a = t_a[i]; req0_b = t_b[i];
            wait_ready(0, ok);
            check("t6_wait_ready", ok, 1);
            tick();
        end
        req0_valid = 0;
        repeat (3) tick();
        check("t6_accepts", acc_cyc_q.size(), 4);
        for (int i = 1; i < 4; i++) check("t6_spacing", acc_cyc_q[i] - acc_cyc_q[i-1], 3);
        check("t6_rsp_count", rsp0_q.size(), 4);
        for (int i = 0; i < 4; i++) check("t6_rsp", rsp0_q[i], t_r[i]);

        // Randomized traffic with back-pressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            if (!req0_valid || acc0) begin
                req0_valid = $urandom_range(0, 1) == 1;
                req0_op = OPW'($urandom());
                req0_a = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom());
                req0_b = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom());
            end
            if (!req1_valid || acc1) begin
                req1_valid = $urandom_range(0, 1) == 1;
                req1_op = OPW'($urandom());
                req1_a = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom());
                req1_b = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom());
            end
            rsp0_ready = $urandom_range(0, 3) != 0;
            rsp1_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 199) == 0;
            tick();
        end
        rst = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
